// File: rtl/hazard_ctrl_pkg.sv
// Shared hazard-control definitions: ISA widths, the load opcode and FSM state encodings.
// Both HAZARD_HEADER_VH and this package are consumed by hazard_ctrl and hazard_lu_detect.
`ifndef HAZARD_HEADER_VH
`define HAZARD_HEADER_VH
`define XLEN        32
`define XADDR       5
`define OPLEN       7
`define L_OP        7'b0000011
`define ST_RUN      1'b0
`define ST_MEM_WAIT 1'b1
`endif

package hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = `ST_RUN,
        MEM_WAIT = `ST_MEM_WAIT
    } state_e;

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use detector: the EX-stage load writes a register that ID reads.
// A destination of x0 never matches, so x0 sources cannot raise a hazard.
module hazard_lu_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [`XADDR-1:0] rs1_addr,
    input  logic [`XADDR-1:0] rs2_addr,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [`OPLEN-1:0] opcode,
    input  logic [`XADDR-1:0] rd_addr,
    output logic              load_use
);

    logic is_load;
    logic rd_nonzero;
    logic rs1_hit;
    logic rs2_hit;

    assign is_load    = (opcode == `L_OP);
    assign rd_nonzero = (rd_addr != '0);
    assign rs1_hit    = rs1_used && (rs1_addr == rd_addr);
    assign rs2_hit    = rs2_used && (rs2_addr == rd_addr);
    assign load_use   = is_load && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM plus branch and load-use stall/flush generation.
// Optional HAZARD_STALL_CNT_EN adds a saturating 32-bit count of IF-stall cycles on o_stall_cnt.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [`XADDR-1:0] i_rs1_addr_id,
    input  logic [`XADDR-1:0] i_rs2_addr_id,
    input  logic              i_rs1_used_id,
    input  logic              i_rs2_used_id,
    input  logic [`OPLEN-1:0] i_opcode_ex,
    input  logic [`XADDR-1:0] i_rd_addr_ex,
    input  logic              i_branch_taken_ex,
    input  logic              i_mem_req_valid,
    input  logic              i_mem_req_complete,
    output logic              o_stall_if,
    output logic              o_stall_id,
    output logic              o_stall_ex,
    output logic              o_stall_mem,
    output logic              o_flush_id,
    output logic              o_bubble_ex,
    output logic              o_mem_wait
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [`XLEN-1:0]  o_stall_cnt
`endif
);

    state_e state_q;
    state_e state_d;
    logic   mem_stall;
    logic   load_use;

    hazard_lu_detect u_lu_detect (
        .rs1_addr (i_rs1_addr_id),
        .rs2_addr (i_rs2_addr_id),
        .rs1_used (i_rs1_used_id),
        .rs2_used (i_rs2_used_id),
        .opcode   (i_opcode_ex),
        .rd_addr  (i_rd_addr_ex),
        .load_use (load_use)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are gated by reset so they drop the instant reset asserts, whatever the inputs.
    always_comb begin
        state_d     = state_q;
        mem_stall   = 1'b0;
        o_stall_if  = 1'b0;
        o_stall_id  = 1'b0;
        o_stall_ex  = 1'b0;
        o_stall_mem = 1'b0;
        o_flush_id  = 1'b0;
        o_bubble_ex = 1'b0;
        o_mem_wait  = 1'b0;

        case (state_q)
            RUN: begin
                mem_stall = i_mem_req_valid && !i_mem_req_complete;
                if (mem_stall) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                mem_stall = !i_mem_req_complete;
                if (i_mem_req_complete) state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        if (i_rst_n) begin
            o_mem_wait = (state_q == MEM_WAIT);
            // EX is frozen during a memory stall, so a held-off branch or load-use
            // is simply re-evaluated once the stall releases.
            if (mem_stall) begin
                o_stall_if  = 1'b1;
                o_stall_id  = 1'b1;
                o_stall_ex  = 1'b1;
                o_stall_mem = 1'b1;
            end else if (i_branch_taken_ex) begin
                o_flush_id  = 1'b1;
                o_bubble_ex = 1'b1;
            end else if (load_use) begin
                o_stall_if  = 1'b1;
                o_stall_id  = 1'b1;
                o_bubble_ex = 1'b1;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [`XLEN-1:0] stall_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (o_stall_if && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have port i_clk, input, 1 bit: the single pipeline clock; all state changes on its rising edge.
REQ-002 The module SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The module SHALL have ports i_rs1_addr_id and i_rs2_addr_id, inputs, `XADDR bits each: source register addresses of the instruction in decode.
REQ-004 The module SHALL have ports i_rs1_used_id and i_rs2_used_id, inputs, 1 bit each: the decode instruction actually reads that source.
REQ-005 The module SHALL have ports i_opcode_ex (input, `OPLEN bits) and i_rd_addr_ex (input, `XADDR bits): opcode and destination of the execute-stage instruction.
REQ-006 The module SHALL have port i_branch_taken_ex, input, 1 bit: execute stage redirects the PC this cycle.
REQ-007 The module SHALL have ports i_mem_req_valid and i_mem_req_complete, inputs, 1 bit each: memory stage has an outstanding load/store, and that request finishes this cycle.
REQ-008 The module SHALL have ports o_stall_if, o_stall_id, o_stall_ex and o_stall_mem, outputs, 1 bit each: hold the corresponding pipeline register.
REQ-009 The module SHALL have ports o_flush_id and o_bubble_ex, outputs, 1 bit each: replace the ID/EX-bound instruction with a NOP.
REQ-010 The module SHALL have port o_mem_wait, output, 1 bit: FSM is in MEM_WAIT.

Function
REQ-011 The FSM SHALL have two states, RUN and MEM_WAIT.
REQ-012 RUN to MEM_WAIT SHALL occur when i_mem_req_valid=1 and i_mem_req_complete=0.
REQ-013 MEM_WAIT to RUN SHALL occur in the cycle i_mem_req_complete=1.
REQ-014 mem_stall SHALL be defined as i_mem_req_valid & ~i_mem_req_complete (in RUN), or ~i_mem_req_complete (in MEM_WAIT).
REQ-015 When mem_stall=1, all four stall outputs SHALL be 1 in that same cycle (combinational), and o_flush_id and o_bubble_ex SHALL be 0.
REQ-016 Valid and complete in the same RUN cycle SHALL produce zero stall cycles.
REQ-017 Load-use SHALL be detected when i_opcode_ex==`L_OP, i_rd_addr_ex!=0, and (i_rs1_used_id & rs1 match) | (i_rs2_used_id & rs2 match).
REQ-018 Load-use with no mem_stall and no branch SHALL drive o_stall_if=1, o_stall_id=1, o_bubble_ex=1 for exactly one cycle; o_stall_ex and o_stall_mem SHALL stay 0.
REQ-019 i_branch_taken_ex with no mem_stall SHALL drive o_flush_id=1 and o_bubble_ex=1 for one cycle, all stalls 0, and SHALL suppress load-use detection.
REQ-020 Priority SHALL be mem_stall > branch > load-use.
REQ-021 A branch or load-use arising during mem_stall SHALL be held off and evaluated in the cycle the stall releases; no pending register is needed because EX is frozen.
REQ-022 A source address of x0 SHALL never create a hazard.
REQ-023 o_mem_wait SHALL equal (state==MEM_WAIT).

Reset
REQ-024 While i_rst_n=0, the FSM SHALL be RUN and every output SHALL be 0, regardless of the other inputs.
REQ-025 Assertion of reset mid-MEM_WAIT SHALL abort the wait immediately.
REQ-026 The first rising edge after deassertion SHALL evaluate from RUN.

Configuration
REQ-027 With HAZARD_STALL_CNT_EN defined, the module SHALL add output o_stall_cnt (32 bits).
REQ-028 o_stall_cnt SHALL reset to 0, increment on each clock with o_stall_if=1, and saturate at 0xFFFFFFFF.
REQ-029 Without HAZARD_STALL_CNT_EN, the port and counter SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-030 `XLEN, `XADDR, `OPLEN, `L_OP and the state encodings SHALL live in the shared header.vh.
REQ-031 The load-use compare SHALL be a combinational sub-module, hazard_lu_detect; the FSM and counter SHALL stay in hazard_ctrl.

Verification
REQ-032 Bench SHALL cover load-use: EX lw rd=x5, ID add rs1=x5 used -> one cycle of stall_if/id=1 and bubble_ex=1, then all 0.
REQ-033 Bench SHALL cover x0: EX lw rd=x0, ID rs1=x0 -> no stall, no bubble.
REQ-034 Bench SHALL cover mem wait: valid=1, complete=0 for 3 cycles, then 1 -> four stalls high 3 cycles, o_mem_wait high cycles 2-4, RUN after; valid and complete both 1 together -> 0 stalls.
REQ-035 Bench SHALL cover branch plus load-use in the same cycle: branch_taken=1 with an rs2 match -> flush_id=1, bubble_ex=1, stall_if=0.
REQ-036 Bench SHALL cover reset: i_rst_n=0 in cycle 2 of MEM_WAIT -> outputs 0 at once, RUN after release; with HAZARD_STALL_CNT_EN, counter preloaded near max (force) stays 0xFFFFFFFF under stalls.
